// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station and the instruction queue.
// Provides the no-op encoding, default geometry and the per-entry payload record.
package reservation_station_pkg;
  localparam int          DATA_W       = 32;
  localparam int          RS_DEPTH_DEF = 8;
  localparam int          TAG_W_DEF    = 4;
  localparam logic [4:0]  OP_NOP       = 5'b11111;
  localparam logic [4:0]  OP_ADD       = 5'b00000;
  localparam logic [4:0]  OP_SUB       = 5'b00001;

  // Payload held in each entry; the tag fields live beside it because their
  // width follows the instantiating module's TAG_W.
  typedef struct packed {
    logic [4:0]        op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
  } rs_entry_t;
endpackage

// File: rtl/rs_pick.sv
// Lowest-set-bit priority encoder.
// Ports: req   - request vector
//        idx   - index of the lowest set bit (0 when none)
//        found - at least one bit of req is set
module rs_pick #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers decoded operations until both operands are
// available (direct or via CDB wake-up) and issues the lowest-index ready entry
// into a registered ALU interface.
// Ports: clk, rst (async, active-low); op_in/imm_in/has_imm_in/rob_tag_in and
//        vj/qj/rj_rdy, vk/qk/rk_rdy operand inputs; cdb_valid/tag/value
//        broadcast; flush; exec_ready handshake; exec_valid/op/a/b/tag issue
//        register; rs_full registered back-pressure.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op_in,
  input  logic [31:0]      imm_in,
  input  logic             has_imm_in,
  input  logic [TAG_W-1:0] rob_tag_in,
  input  logic [31:0]      vj_in,
  input  logic [TAG_W-1:0] qj_in,
  input  logic             rj_rdy_in,
  input  logic [31:0]      vk_in,
  input  logic [TAG_W-1:0] qk_in,
  input  logic             rk_rdy_in,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             flush,
  input  logic             exec_ready,
  output logic             exec_valid,
  output logic [4:0]       exec_op,
  output logic [31:0]      exec_a,
  output logic [31:0]      exec_b,
  output logic [TAG_W-1:0] exec_tag,
  output logic             rs_full
);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  logic [RS_DEPTH-1:0] busy, rj, rk, rdy_vec;
  rs_entry_t           ent  [RS_DEPTH];
  logic [TAG_W-1:0]    qj   [RS_DEPTH];
  logic [TAG_W-1:0]    qk   [RS_DEPTH];
  logic [TAG_W-1:0]    dtag [RS_DEPTH];
  logic [CNT_W-1:0]    count, count_nxt;
  logic [IDX_W-1:0]    alloc_idx, iss_idx;
  logic                alloc_found, iss_found;
  logic                do_alloc, do_issue;
  logic                new_rj, new_rk;
  logic [31:0]         new_vj, new_vk;

  // Both searches look at start-of-cycle state: an entry freed by this edge's
  // issue is not reused until next cycle, and a wake-up issues one cycle later.
  assign rdy_vec = busy & rj & rk;

  rs_pick #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_free_pick (
    .req   (~busy),
    .idx   (alloc_idx),
    .found (alloc_found)
  );

  rs_pick #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_iss_pick (
    .req   (rdy_vec),
    .idx   (iss_idx),
    .found (iss_found)
  );

  assign do_alloc  = !flush && (op_in != OP_NOP) && alloc_found;
  assign do_issue  = !flush && iss_found && (!exec_valid || exec_ready);
  assign count_nxt = count + CNT_W'(do_alloc) - CNT_W'(do_issue);

  // Operand state for a newly allocated entry, including a CDB hit on the
  // same edge. The immediate overrides operand B entirely.
  assign new_rj = rj_rdy_in || (cdb_valid && (cdb_tag == qj_in));
  assign new_vj = rj_rdy_in ? vj_in : cdb_value;
  assign new_rk = has_imm_in || rk_rdy_in || (cdb_valid && (cdb_tag == qk_in));
  assign new_vk = has_imm_in ? imm_in : (rk_rdy_in ? vk_in : cdb_value);

  // Control and issue register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      rj         <= '0;
      rk         <= '0;
      count      <= '0;
      rs_full    <= 1'b0;
      exec_valid <= 1'b0;
      exec_op    <= OP_NOP;
      exec_a     <= '0;
      exec_b     <= '0;
      exec_tag   <= '0;
    end else if (flush) begin
      busy       <= '0;
      rj         <= '0;
      rk         <= '0;
      count      <= '0;
      rs_full    <= 1'b0;
      exec_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (cdb_valid && busy[i]) begin
          if (!rj[i] && (qj[i] == cdb_tag)) rj[i] <= 1'b1;
          if (!rk[i] && (qk[i] == cdb_tag)) rk[i] <= 1'b1;
        end
      end
      if (do_issue) busy[iss_idx] <= 1'b0;
      if (do_alloc) begin
        busy[alloc_idx] <= 1'b1;
        rj[alloc_idx]   <= new_rj;
        rk[alloc_idx]   <= new_rk;
      end
      count   <= count_nxt;
      rs_full <= (count_nxt >= CNT_W'(RS_DEPTH - 1));
      if (do_issue) begin
        exec_valid <= 1'b1;
        exec_op    <= ent[iss_idx].op;
        exec_a     <= ent[iss_idx].vj;
        exec_b     <= ent[iss_idx].vk;
        exec_tag   <= dtag[iss_idx];
      end else if (exec_valid && exec_ready) begin
        exec_valid <= 1'b0;
      end
    end
  end

  // Entry payload; meaningful only while the matching busy bit is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cdb_valid && busy[i]) begin
        if (!rj[i] && (qj[i] == cdb_tag)) ent[i].vj <= cdb_value;
        if (!rk[i] && (qk[i] == cdb_tag)) ent[i].vk <= cdb_value;
      end
    end
    if (do_alloc) begin
      ent[alloc_idx]  <= '{op: op_in, vj: new_vj, vk: new_vk};
      qj[alloc_idx]   <= qj_in;
      qk[alloc_idx]   <= qk_in;
      dtag[alloc_idx] <= rob_tag_in;
    end
  end
endmodule
